read_arbiter: RTL and testbench

Arbitrates the N per-port transmit read controllers onto the single shared packet-memory read port and the single free-list release port. It is the read-side counterpart of the write/allocation arbiter and sits between the tx read controllers, packet memory and free list. Both resources use work-conserving round-robin. The block tracks in-flight reads so each returned data word is steered to the port that issued it.

---
 rtl/mem_pkg.sv | 5 +
 rtl/read_arbiter_if.sv | 41 ++++
 rtl/read_arbiter.sv | 133 +++++++++++++
 tb/tb_read_arbiter.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared packet-memory geometry used by the read arbiter and its interface.
package mem_pkg;
  localparam int ADDR_W     = 8;
  localparam int BLOCK_BITS = 32;
endpackage

// File: rtl/read_arbiter_if.sv
// Bundle of the per-port read/release request buses and the shared memory /
// free-list side signals of the read arbiter.
interface read_arbiter_if #(
  parameter int N          = 4,
  parameter int ADDR_W     = mem_pkg::ADDR_W,
  parameter int BLOCK_BITS = mem_pkg::BLOCK_BITS
);
  // tx read controllers side
  logic [N-1:0]             mem_re_i;
  logic [N-1:0][ADDR_W-1:0] mem_raddr_i;
  logic [N-1:0]             mem_rgnt_o;
  logic [N-1:0]             mem_rvalid_o;
  logic [BLOCK_BITS-1:0]    mem_rdata_o;
  logic [N-1:0]             fl_free_req_i;
  logic [N-1:0][ADDR_W-1:0] fl_free_block_idx_i;
  logic [N-1:0]             fl_free_gnt_o;
  // packet memory side
  logic                     mem_re_o;
  logic [ADDR_W-1:0]        mem_raddr_o;
  logic [BLOCK_BITS-1:0]    mem_rdata_i;
  // free list side
  logic                     fl_free_req_o;
  logic [ADDR_W-1:0]        fl_free_block_idx_o;
  logic                     fl_free_rdy_i;

  // Arbiter view
  modport slave (
    input  mem_re_i, mem_raddr_i, mem_rdata_i,
           fl_free_req_i, fl_free_block_idx_i, fl_free_rdy_i,
    output mem_rgnt_o, mem_rvalid_o, mem_rdata_o, mem_re_o, mem_raddr_o,
           fl_free_gnt_o, fl_free_req_o, fl_free_block_idx_o
  );

  // Requester / memory / free-list view
  modport master (
    output mem_re_i, mem_raddr_i, mem_rdata_i,
           fl_free_req_i, fl_free_block_idx_i, fl_free_rdy_i,
    input  mem_rgnt_o, mem_rvalid_o, mem_rdata_o, mem_re_o, mem_raddr_o,
           fl_free_gnt_o, fl_free_req_o, fl_free_block_idx_o
  );
endinterface

// File: rtl/read_arbiter.sv
// Round-robin arbiter of N tx read controllers onto the shared packet-memory
// read port and the free-list release port. In-flight reads are tracked in an
// RD_LAT-deep pipeline so returned data is flagged for the issuing port.
module read_arbiter #(
  parameter int N          = 4,
  parameter int RD_LAT     = 1,
  parameter int ADDR_W     = mem_pkg::ADDR_W,
  parameter int BLOCK_BITS = mem_pkg::BLOCK_BITS
) (
  input  logic          clk,
  input  logic          rst_n,
  read_arbiter_if.slave bus
);

  localparam int PTR_W = (N > 1) ? $clog2(N) : 1;

  // Increment a port pointer with an explicit wrap at N-1.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(N - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // First requester scanning from ptr upward with wrap; returns {found, index}.
  function automatic logic [PTR_W:0] rr_pick(input logic [N-1:0]     req,
                                             input logic [PTR_W-1:0] ptr);
    logic [PTR_W-1:0] cand;
    logic [PTR_W-1:0] win;
    logic             found;
    cand  = ptr;
    win   = '0;
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!found && req[cand]) begin
        found = 1'b1;
        win   = cand;
      end
      cand = ptr_inc(cand);
    end
    return {found, win};
  endfunction

  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] fl_ptr;

  logic             rd_found;
  logic [PTR_W-1:0] rd_win;
  logic             fl_found;
  logic [PTR_W-1:0] fl_win;

  logic [N-1:0]      rd_gnt;
  logic [ADDR_W-1:0] rd_addr;
  logic [N-1:0]      fl_gnt;
  logic [ADDR_W-1:0] fl_idx;
  logic              fl_take;
  logic [N-1:0]      rvalid;

  logic [RD_LAT-1:0] pipe_vld;
  logic [PTR_W-1:0]  pipe_id [RD_LAT];

  // Read-port winner, grant vector and address mux.
  always_comb begin
    {rd_found, rd_win} = rr_pick(bus.mem_re_i, rd_ptr);
    rd_gnt  = '0;
    rd_addr = '0;
    if (rd_found) begin
      rd_gnt[rd_win] = 1'b1;
      rd_addr        = bus.mem_raddr_i[rd_win];
    end else begin
      rd_gnt  = '0;
      rd_addr = '0;
    end
  end

  // Release-port winner; grant only when the free list is ready.
  always_comb begin
    {fl_found, fl_win} = rr_pick(bus.fl_free_req_i, fl_ptr);
    fl_gnt  = '0;
    fl_idx  = '0;
    fl_take = fl_found & bus.fl_free_rdy_i;
    if (fl_found) begin
      fl_gnt[fl_win] = bus.fl_free_rdy_i;
      fl_idx         = bus.fl_free_block_idx_i[fl_win];
    end else begin
      fl_gnt = '0;
      fl_idx = '0;
    end
  end

  // Round-robin pointers move past the winner after each granted transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      fl_ptr <= '0;
    end else begin
      if (rd_found) rd_ptr <= ptr_inc(rd_win);
      if (fl_take)  fl_ptr <= ptr_inc(fl_win);
    end
  end

  // In-flight read tracker: {valid, port id} shifted once per cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_vld <= '0;
      for (int i = 0; i < RD_LAT; i++) pipe_id[i] <= '0;
    end else begin
      pipe_vld[0] <= rd_found;
      pipe_id[0]  <= rd_win;
      for (int i = 1; i < RD_LAT; i++) begin
        pipe_vld[i] <= pipe_vld[i-1];
        pipe_id[i]  <= pipe_id[i-1];
      end
    end
  end

  // Steer the returning data-valid to the port that issued the read.
  always_comb begin
    rvalid = '0;
    if (pipe_vld[RD_LAT-1]) begin
      rvalid[pipe_id[RD_LAT-1]] = 1'b1;
    end else begin
      rvalid = '0;
    end
  end

  assign bus.mem_rgnt_o          = rd_gnt;
  assign bus.mem_re_o            = rd_found;
  assign bus.mem_raddr_o         = rd_addr;
  assign bus.mem_rvalid_o        = rvalid;
  assign bus.mem_rdata_o         = bus.mem_rdata_i;
  assign bus.fl_free_gnt_o       = fl_gnt;
  assign bus.fl_free_req_o       = |bus.fl_free_req_i;
  assign bus.fl_free_block_idx_o = fl_idx;

endmodule

// File: tb/tb_read_arbiter.sv
// Directed bench for read_arbiter: three instances (N=4/RD_LAT=1,
// N=4/RD_LAT=3, N=3/RD_LAT=1) sharing clock and reset.
module tb_read_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  read_arbiter_if #(.N(4)) ifa ();
  read_arbiter_if #(.N(4)) ifb ();
  read_arbiter_if #(.N(3)) ifc ();

  read_arbiter #(.N(4), .RD_LAT(1)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
  read_arbiter #(.N(4), .RD_LAT(3)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));
  read_arbiter #(.N(3), .RD_LAT(1)) dut_c (.clk(clk), .rst_n(rst_n), .bus(ifc));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    #1;
    n_cmp++; if (ifa.mem_rgnt_o !== 4'b0000) begin n_err++; $display("FAIL rst_gnt_a got %b want %b", ifa.mem_rgnt_o, 4'b0000); end
    n_cmp++; if (ifa.mem_re_o !== 1'b0) begin n_err++; $display("FAIL rst_re_a got %b want 0", ifa.mem_re_o); end
    n_cmp++; if (ifa.mem_rvalid_o !== 4'b0000) begin n_err++; $display("FAIL rst_rvalid_a got %b want 0000", ifa.mem_rvalid_o); end
    n_cmp++; if (ifb.mem_rvalid_o !== 4'b0000) begin n_err++; $display("FAIL rst_rvalid_b got %b want 0000", ifb.mem_rvalid_o); end
    n_cmp++; if (ifa.fl_free_req_o !== 1'b0 || ifa.fl_free_gnt_o !== 4'b0000) begin n_err++; $display("FAIL rst_fl_a got req=%b gnt=%b want 0/0000", ifa.fl_free_req_o, ifa.fl_free_gnt_o); end
    n_cmp++; if (dut_a.rd_ptr !== 2'd0 || dut_a.fl_ptr !== 2'd0) begin n_err++; $display("FAIL rst_ptr_a got %0d/%0d want 0/0", dut_a.rd_ptr, dut_a.fl_ptr); end
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_single_read();
    ifa.mem_re_i = 4'b0100;
    ifa.mem_raddr_i[2] = 8'h15;
    #1;
    n_cmp++; if (ifa.mem_rgnt_o !== 4'b0100) begin n_err++; $display("FAIL single_gnt got %b want 0100", ifa.mem_rgnt_o); end
    n_cmp++; if (ifa.mem_re_o !== 1'b1) begin n_err++; $display("FAIL single_re got %b want 1", ifa.mem_re_o); end
    n_cmp++; if (ifa.mem_raddr_o !== 8'h15) begin n_err++; $display("FAIL single_addr got %h want 15", ifa.mem_raddr_o); end
    step();
    ifa.mem_re_i = 4'b0000;
    ifa.mem_rdata_i = 32'hCAFE_0015;
    #1;
    n_cmp++; if (ifa.mem_rvalid_o !== 4'b0100) begin n_err++; $display("FAIL single_rvalid got %b want 0100", ifa.mem_rvalid_o); end
    n_cmp++; if (ifa.mem_rdata_o !== 32'hCAFE_0015) begin n_err++; $display("FAIL single_rdata got %h want cafe0015", ifa.mem_rdata_o); end
    n_cmp++; if (dut_a.rd_ptr !== 2'd3) begin n_err++; $display("FAIL single_ptr got %0d want 3", dut_a.rd_ptr); end
    n_cmp++; if (ifa.mem_re_o !== 1'b0 || ifa.mem_raddr_o !== 8'h00) begin n_err++; $display("FAIL single_idle got re=%b addr=%h want 0/00", ifa.mem_re_o, ifa.mem_raddr_o); end
    step();
    n_cmp++; if (ifa.mem_rvalid_o !== 4'b0000) begin n_err++; $display("FAIL single_rvalid_end got %b want 0000", ifa.mem_rvalid_o); end
  endtask

  task automatic test_full_load();
    logic [3:0] exp_g, exp_va, exp_vb;
    do_reset();
    for (int k = 0; k < 11; k++) begin
      ifa.mem_re_i = (k < 8) ? 4'hF : 4'h0;
      ifb.mem_re_i = (k < 8) ? 4'hF : 4'h0;
      #1;
      exp_g  = (k < 8) ? 4'(1 << (k % 4)) : 4'b0000;
      exp_va = (k >= 1 && k <= 8) ? 4'(1 << ((k - 1) % 4)) : 4'b0000;
      exp_vb = (k >= 3 && k <= 10) ? 4'(1 << ((k - 3) % 4)) : 4'b0000;
      n_cmp++; if (ifa.mem_rgnt_o !== exp_g) begin n_err++; $display("FAIL full_gnt_a cyc %0d got %b want %b", k, ifa.mem_rgnt_o, exp_g); end
      n_cmp++; if (ifb.mem_rgnt_o !== exp_g) begin n_err++; $display("FAIL full_gnt_b cyc %0d got %b want %b", k, ifb.mem_rgnt_o, exp_g); end
      n_cmp++; if (ifa.mem_rvalid_o !== exp_va) begin n_err++; $display("FAIL full_rvalid_a cyc %0d got %b want %b", k, ifa.mem_rvalid_o, exp_va); end
      n_cmp++; if (ifb.mem_rvalid_o !== exp_vb) begin n_err++; $display("FAIL full_rvalid_b cyc %0d got %b want %b", k, ifb.mem_rvalid_o, exp_vb); end
      step();
    end
  endtask

  task automatic test_work_conservation();
    ifa.mem_re_i = 4'b0001;
    #1;
    n_cmp++; if (ifa.mem_rgnt_o !== 4'b0001) begin n_err++; $display("FAIL wc_pre_gnt got %b want 0001", ifa.mem_rgnt_o); end
    step();
    n_cmp++; if (dut_a.rd_ptr !== 2'd1) begin n_err++; $display("FAIL wc_ptr got %0d want 1", dut_a.rd_ptr); end
    ifa.mem_re_i = 4'b1001;
    #1;
    n_cmp++; if (ifa.mem_rgnt_o !== 4'b1000 || ifa.mem_re_o !== 1'b1) begin n_err++; $display("FAIL wc_first got gnt=%b re=%b want 1000/1", ifa.mem_rgnt_o, ifa.mem_re_o); end
    step();
    ifa.mem_re_i = 4'b0001;
    #1;
    n_cmp++; if (ifa.mem_rgnt_o !== 4'b0001 || ifa.mem_re_o !== 1'b1) begin n_err++; $display("FAIL wc_second got gnt=%b re=%b want 0001/1", ifa.mem_rgnt_o, ifa.mem_re_o); end
    n_cmp++; if (ifa.mem_rvalid_o !== 4'b1000) begin n_err++; $display("FAIL wc_rvalid got %b want 1000", ifa.mem_rvalid_o); end
    step();
    ifa.mem_re_i = 4'b0000;
  endtask

  task automatic test_release_backpressure();
    ifa.fl_free_req_i = 4'b0110;
    ifa.fl_free_block_idx_i[1] = 8'h07;
    ifa.fl_free_block_idx_i[2] = 8'h09;
    ifa.fl_free_rdy_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      n_cmp++; if (ifa.fl_free_req_o !== 1'b1 || ifa.fl_free_block_idx_o !== 8'h07) begin n_err++; $display("FAIL bp_offer cyc %0d got req=%b idx=%h want 1/07", k, ifa.fl_free_req_o, ifa.fl_free_block_idx_o); end
      n_cmp++; if (ifa.fl_free_gnt_o !== 4'b0000) begin n_err++; $display("FAIL bp_nogrant cyc %0d got %b want 0000", k, ifa.fl_free_gnt_o); end
      step();
    end
    ifa.fl_free_rdy_i = 1'b1;
    #1;
    n_cmp++; if (ifa.fl_free_gnt_o !== 4'b0010 || ifa.fl_free_block_idx_o !== 8'h07) begin n_err++; $display("FAIL bp_gnt1 got gnt=%b idx=%h want 0010/07", ifa.fl_free_gnt_o, ifa.fl_free_block_idx_o); end
    step();
    ifa.fl_free_req_i = 4'b0100;
    #1;
    n_cmp++; if (ifa.fl_free_gnt_o !== 4'b0100 || ifa.fl_free_block_idx_o !== 8'h09) begin n_err++; $display("FAIL bp_gnt2 got gnt=%b idx=%h want 0100/09", ifa.fl_free_gnt_o, ifa.fl_free_block_idx_o); end
    step();
    ifa.fl_free_req_i = 4'b0000;
    #1;
    n_cmp++; if (ifa.fl_free_req_o !== 1'b0 || ifa.fl_free_block_idx_o !== 8'h00 || dut_a.fl_ptr !== 2'd3) begin n_err++; $display("FAIL bp_idle got req=%b idx=%h ptr=%0d want 0/00/3", ifa.fl_free_req_o, ifa.fl_free_block_idx_o, dut_a.fl_ptr); end
    ifa.fl_free_rdy_i = 1'b0;
    step();
  endtask

  task automatic test_reset_midflight();
    do_reset();
    ifb.mem_re_i = 4'b0001;
    #1;
    n_cmp++; if (ifb.mem_rgnt_o !== 4'b0001) begin n_err++; $display("FAIL mid_gnt0 got %b want 0001", ifb.mem_rgnt_o); end
    step();
    ifb.mem_re_i = 4'b0010;
    #1;
    n_cmp++; if (ifb.mem_rgnt_o !== 4'b0010) begin n_err++; $display("FAIL mid_gnt1 got %b want 0010", ifb.mem_rgnt_o); end
    step();
    ifb.mem_re_i = 4'b0000;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (dut_b.rd_ptr !== 2'd0 || dut_b.fl_ptr !== 2'd0) begin n_err++; $display("FAIL mid_ptr got %0d/%0d want 0/0", dut_b.rd_ptr, dut_b.fl_ptr); end
    step();
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      n_cmp++; if (ifb.mem_rvalid_o !== 4'b0000) begin n_err++; $display("FAIL mid_rvalid cyc %0d got %b want 0000", k, ifb.mem_rvalid_o); end
      step();
    end
  endtask

  task automatic test_n3_wrap();
    logic [2:0] exp_g;
    do_reset();
    for (int k = 0; k < 7; k++) begin
      ifc.mem_re_i = 3'b111;
      #1;
      exp_g = 3'(1 << (k % 3));
      n_cmp++; if (ifc.mem_rgnt_o !== exp_g) begin n_err++; $display("FAIL n3_gnt cyc %0d got %b want %b", k, ifc.mem_rgnt_o, exp_g); end
      n_cmp++; if (dut_c.rd_ptr !== 2'(k % 3)) begin n_err++; $display("FAIL n3_ptr cyc %0d got %0d want %0d", k, dut_c.rd_ptr, k % 3); end
      step();
    end
    ifc.mem_re_i = 3'b000;
  endtask

  initial begin
    ifa.mem_re_i = '0; ifa.mem_raddr_i = '0; ifa.mem_rdata_i = '0;
    ifa.fl_free_req_i = '0; ifa.fl_free_block_idx_i = '0; ifa.fl_free_rdy_i = 1'b0;
    ifb.mem_re_i = '0; ifb.mem_raddr_i = '0; ifb.mem_rdata_i = '0;
    ifb.fl_free_req_i = '0; ifb.fl_free_block_idx_i = '0; ifb.fl_free_rdy_i = 1'b0;
    ifc.mem_re_i = '0; ifc.mem_raddr_i = '0; ifc.mem_rdata_i = '0;
    ifc.fl_free_req_i = '0; ifc.fl_free_block_idx_i = '0; ifc.fl_free_rdy_i = 1'b0;
    test_reset();
    test_single_read();
    test_full_load();
    test_work_conservation();
    test_release_backpressure();
    test_reset_midflight();
    test_n3_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
